// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/stall sequencing for the E-stage multiply-divide unit.
// Define MDU_FLUSH_EN to let Flush squash a not-yet-issued E-stage MDU op.
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int STAT_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        E_MDType,
    input  logic              D_UseMDU,
    input  logic              Flush,
    output logic [3:0]        MD_TypeOut,
    output logic [31:0]       MD_CalTime,
    output logic              Issue,
    output logic              Busy,
    output logic              Done,
    output logic              Stall,
    output logic [STAT_W-1:0] IssueCnt,
    output logic [STAT_W-1:0] StallCnt
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] MULT_LAT = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LAT  = 8'(DIV_CYCLES);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [STAT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              kill, idle, is_long, is_mult, last;
    logic [7:0]        lat;

`ifdef MDU_FLUSH_EN
    assign kill = Flush;
`else
    logic unused_flush;
    assign unused_flush = Flush;
    assign kill         = 1'b0;
`endif

    assign idle     = (state_q == IDLE);
    assign Busy     = (state_q == RUN);
    assign Done     = done_q;
    assign IssueCnt = issue_cnt_q;
    assign StallCnt = stall_cnt_q;

    always_comb begin
        is_long     = E_MDType inside {4'd1, 4'd2, 4'd3, 4'd4};
        is_mult     = E_MDType inside {4'd1, 4'd2};
        lat         = is_mult ? MULT_LAT : DIV_LAT;
        last        = Busy & (cnt_q == 8'd1);
        Issue       = ~Reset & idle & is_long & ~kill;
        Stall       = ~Reset & D_UseMDU & (Busy | Issue);
        MD_TypeOut  = (~Reset & idle & ~kill) ? E_MDType : 4'd0;
        MD_CalTime  = Issue ? {24'd0, lat} : 32'd0;
        // HI/LO are written on the edge leaving RUN, so Done lands one cycle later
        done_d      = ~Reset & last;
        state_d     = Reset ? IDLE : Issue ? RUN : last ? IDLE : state_q;
        cnt_d       = Reset ? 8'd0 : Issue ? lat : Busy ? cnt_q - 8'd1 : cnt_q;
        issue_cnt_d = Reset ? '0 : issue_cnt_q + STAT_W'(Issue);
        stall_cnt_d = Reset ? '0 : stall_cnt_q + STAT_W'(Stall);
    end

    always_ff @(posedge Clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        done_q      <= done_d;
        issue_cnt_q <= issue_cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: vector table, directed corner sequences and random run against a cycle-count model.
module tb_md_issue_ctrl;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  E_MDType = 4'd0;
    logic        D_UseMDU = 1'b0;
    logic        Flush = 1'b0;
    logic [3:0]  MD_TypeOut;
    logic [31:0] MD_CalTime;
    logic        Issue, Busy, Done, Stall;
    logic [31:0] IssueCnt, StallCnt;

`ifdef MDU_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    md_issue_ctrl dut (
        .Clk(Clk), .Reset(Reset), .E_MDType(E_MDType), .D_UseMDU(D_UseMDU), .Flush(Flush),
        .MD_TypeOut(MD_TypeOut), .MD_CalTime(MD_CalTime), .Issue(Issue), .Busy(Busy),
        .Done(Done), .Stall(Stall), .IssueCnt(IssueCnt), .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // model: remaining busy cycles plus pending Done and the statistics
    int          m_rem = 0;
    bit          m_done = 0;
    logic [31:0] m_icnt = 0, m_scnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] typ, input bit duse, input bit fl);
        bit busy, kill, long_op, iss, stl;
        int lat;
        @(negedge Clk);
        Reset = rst; E_MDType = typ; D_UseMDU = duse; Flush = fl;
        #1;
        busy    = m_rem > 0;
        kill    = FLUSH_EN && fl;
        long_op = typ >= 1 && typ <= 4;
        lat     = (typ <= 2) ? 5 : 10;
        iss     = !rst && !busy && long_op && !kill;
        stl     = !rst && duse && (busy || iss);
        chk("issue", 32'(Issue), 32'(iss));
        chk("busy", 32'(Busy), 32'(busy));
        chk("done", 32'(Done), 32'(m_done));
        chk("stall", 32'(Stall), 32'(stl));
        chk("typeout", 32'(MD_TypeOut), (!rst && !busy && !kill) ? 32'(typ) : 32'd0);
        chk("caltime", MD_CalTime, iss ? 32'(lat) : 32'd0);
        chk("issuecnt", IssueCnt, m_icnt);
        chk("stallcnt", StallCnt, m_scnt);
        if (rst) begin
            m_rem = 0; m_done = 0; m_icnt = 0; m_scnt = 0;
        end else begin
            m_done = (m_rem == 1);
            m_rem  = busy ? m_rem - 1 : iss ? lat : 0;
            m_icnt += 32'(iss);
            m_scnt += 32'(stl);
        end
    endtask

    typedef struct {
        bit rst; logic [3:0] typ;
        bit issue, busy, done, stall; logic [3:0] tout; logic [31:0] cal, icnt;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{0, 1, 1, 0, 0, 0, 1, 5, 0};
        for (int i = 5; i < 10; i++) vt[i] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[12] = '{0, 5, 0, 0, 0, 0, 5, 0, 1};

        step(1, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            step(vt[i].rst, vt[i].typ, 0, 0);
            chk("tbl_issue", 32'(Issue), 32'(vt[i].issue));
            chk("tbl_busy", 32'(Busy), 32'(vt[i].busy));
            chk("tbl_done", 32'(Done), 32'(vt[i].done));
            chk("tbl_stall", 32'(Stall), 32'(vt[i].stall));
            chk("tbl_typeout", 32'(MD_TypeOut), 32'(vt[i].tout));
            chk("tbl_caltime", MD_CalTime, vt[i].cal);
            chk("tbl_issuecnt", IssueCnt, vt[i].icnt);
        end

        // div with a D-stage MDU op waiting: issue cycle + 10 RUN cycles of stall
        step(1, 0, 0, 0);
        step(0, 3, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("div_stall_release", 32'(Stall), 32'd0);
        chk("div_done", 32'(Done), 32'd1);
        chk("div_stallcnt", StallCnt, 32'd11);

        // mthi forced into E during RUN is suppressed and the countdown continues
        step(1, 0, 0, 0);
        step(0, 4, 0, 0);
        step(0, 7, 0, 0);
        chk("run_mthi_typeout", 32'(MD_TypeOut), 32'd0);
        chk("run_mthi_issue", 32'(Issue), 32'd0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("divu_done", 32'(Done), 32'd1);

        // multu with Flush in IDLE
        step(1, 0, 0, 0);
        step(0, 2, 0, 1);
        chk("flush_issue", 32'(Issue), FLUSH_EN ? 32'd0 : 32'd1);
        chk("flush_caltime", MD_CalTime, FLUSH_EN ? 32'd0 : 32'd5);
        step(0, 0, 0, 0);
        chk("flush_busy", 32'(Busy), FLUSH_EN ? 32'd0 : 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // Reset on third RUN cycle of div, then a Done/Issue overlap
        step(1, 0, 0, 0);
        step(0, 3, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_issuecnt", IssueCnt, 32'd0);
        chk("rst_stallcnt", StallCnt, 32'd0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 3, 0, 0);
        chk("done_with_issue", 32'(Done & Issue), 32'd1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(63) == 0, 4'($urandom_range(8)), 1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
